// File: rtl/rope_rasterizer.sv
// Walks a polyline of NODES points with Bresenham and streams the visible pixels of one frame.
// Latency: first pixel is presented two cycles after start is accepted; one bubble cycle per segment.
// Backpressure: a presented pixel holds until pix_ready; off-screen points are skipped at one per cycle.
module rope_rasterizer #(
    parameter int NODES    = 20,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NODES*10-1:0] nodes_x,
    input  logic [NODES*10-1:0] nodes_y,
    output logic                pix_valid,
    output logic [9:0]          pix_x,
    output logic [9:0]          pix_y,
    input  logic                pix_ready,
    output logic                busy,
    output logic                done
);

    localparam int                SEG_W    = $clog2(NODES);
    localparam logic [SEG_W-1:0]  LAST_SEG = SEG_W'(NODES - 2);
    localparam logic signed [11:0] LIM_X   = 12'(SCREEN_W);
    localparam logic signed [11:0] LIM_Y   = 12'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame snapshot, frozen for the whole frame
    logic [NODES*10-1:0] r_nx;
    logic [NODES*10-1:0] r_ny;
    logic [SEG_W-1:0]    r_seg;
    logic [SEG_W-1:0]    w_seg_nxt;

    // Walker state for the current segment
    logic signed [11:0] r_cx, r_cy;
    logic signed [11:0] r_ex, r_ey;
    logic signed [11:0] r_dx, r_dy;
    logic signed [11:0] r_sx, r_sy;
    logic signed [11:0] r_err;

    logic [9:0] w_node_x [NODES];
    logic [9:0] w_node_y [NODES];

    genvar g;
    for (g = 0; g < NODES; g++) begin : g_unpack
        assign w_node_x[g] = r_nx[g*10 +: 10];
        assign w_node_y[g] = r_ny[g*10 +: 10];
    end

    assign w_seg_nxt = r_seg + 1'b1;

    // Segment setup terms (used in LOAD)
    logic signed [11:0] w_x0, w_y0, w_x1, w_y1;
    logic signed [11:0] w_ld_dx, w_ld_dy, w_ld_sx, w_ld_sy;
    logic               w_ld_zero;

    assign w_x0 = {2'b00, w_node_x[r_seg]};
    assign w_y0 = {2'b00, w_node_y[r_seg]};
    assign w_x1 = {2'b00, w_node_x[w_seg_nxt]};
    assign w_y1 = {2'b00, w_node_y[w_seg_nxt]};

    // dx is a positive magnitude, dy a negative one, as the error term expects
    assign w_ld_dx   = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
    assign w_ld_sx   = (w_x1 >= w_x0) ? 12'sd1 : -12'sd1;
    assign w_ld_dy   = (w_y1 >= w_y0) ? (w_y0 - w_y1) : (w_y1 - w_y0);
    assign w_ld_sy   = (w_y1 >= w_y0) ? 12'sd1 : -12'sd1;
    assign w_ld_zero = (w_ld_dx == 12'sd0) && (w_ld_dy == 12'sd0);

    // Bresenham step terms (used in DRAW)
    logic signed [11:0] w_e2, w_nx, w_ny, w_nerr;
    logic               w_step_x, w_step_y;
    logic               w_last_seg, w_at_end, w_next_end, w_inrange;
    logic               w_in_draw, w_adv, w_last_pt, w_seg_done;

    assign w_e2     = r_err <<< 1;
    assign w_step_x = (w_e2 >= r_dy);
    assign w_step_y = (w_e2 <= r_dx);
    assign w_nx     = w_step_x ? (r_cx + r_sx) : r_cx;
    assign w_ny     = w_step_y ? (r_cy + r_sy) : r_cy;
    assign w_nerr   = r_err + (w_step_x ? r_dy : 12'sd0) + (w_step_y ? r_dx : 12'sd0);

    assign w_last_seg = (r_seg == LAST_SEG);
    assign w_at_end   = (r_cx == r_ex) && (r_cy == r_ey);
    assign w_next_end = (w_nx == r_ex) && (w_ny == r_ey);
    assign w_inrange  = (r_cx < LIM_X) && (r_cy < LIM_Y);
    assign w_in_draw  = (r_state == DRAW);
    // Clipped points never wait for the writer
    assign w_adv      = w_in_draw && (!w_inrange || pix_ready);
    // Only the final segment ever sits on its own end point
    assign w_last_pt  = w_last_seg && w_at_end;
    // Leave a non-final segment before reaching the shared node, so it is drawn once
    assign w_seg_done = !w_last_seg && w_next_end;

    assign pix_x = r_cx[9:0];
    assign pix_y = r_cy[9:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        pix_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                // Zero-length interior segments are skipped straight to the next LOAD
                if (!(w_ld_zero && !w_last_seg)) begin
                    w_state_nxt = DRAW;
                end
            end
            DRAW: begin
                busy      = 1'b1;
                pix_valid = w_inrange;
                if (w_adv) begin
                    if (w_last_pt) begin
                        w_state_nxt = FINISH;
                    end else if (w_seg_done) begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            FINISH: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot, segment setup and walker datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nx  <= '0;
            r_ny  <= '0;
            r_seg <= '0;
            r_cx  <= '0;
            r_cy  <= '0;
            r_ex  <= '0;
            r_ey  <= '0;
            r_dx  <= '0;
            r_dy  <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
            r_err <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_nx  <= nodes_x;
                        r_ny  <= nodes_y;
                        r_seg <= '0;
                    end
                end
                LOAD: begin
                    r_cx  <= w_x0;
                    r_cy  <= w_y0;
                    r_ex  <= w_x1;
                    r_ey  <= w_y1;
                    r_dx  <= w_ld_dx;
                    r_dy  <= w_ld_dy;
                    r_sx  <= w_ld_sx;
                    r_sy  <= w_ld_sy;
                    r_err <= w_ld_dx + w_ld_dy;
                    if (w_ld_zero && !w_last_seg) begin
                        r_seg <= w_seg_nxt;
                    end
                end
                DRAW: begin
                    if (w_adv && !w_last_pt) begin
                        if (w_seg_done) begin
                            r_seg <= w_seg_nxt;
                        end else begin
                            r_cx  <= w_nx;
                            r_cy  <= w_ny;
                            r_err <= w_nerr;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rope_rasterizer.md
ROPE_RASTERIZER -- requirements
Module: rope_rasterizer

Interface
REQ-001 SHALL have parameter NODES, default 20, number of rope nodes (minimum 2).
REQ-002 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 480, visible height in pixels.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  frame-draw request, sampled each cycle.
REQ-007 nodes_x  input  NODES*10  node X coordinates, node k in bits [10k+9:10k], unsigned.
REQ-008 nodes_y  input  NODES*10  node Y coordinates, same packing.
REQ-009 pix_valid  output  1  pixel coordinate available.
REQ-010 pix_x  output  10  pixel X.
REQ-011 pix_y  output  10  pixel Y.
REQ-012 pix_ready  input  1  framebuffer writer accepts pixel.
REQ-013 busy  output  1  high from start acceptance until done.
REQ-014 done  output  1  one-cycle pulse when frame complete.

Function
REQ-015 SHALL use states IDLE, LOAD, DRAW, FINISH.
REQ-016 In IDLE, start=1 SHALL snapshot nodes_x/nodes_y into internal registers, set segment index to 0, assert busy next cycle, go to LOAD.
REQ-017 start while busy SHALL be ignored; snapshot SHALL NOT change during a frame.
REQ-018 LOAD SHALL take exactly one cycle: cur=(x_i,y_i), dx=|x_{i+1}-x_i|, dy=-|y_{i+1}-y_i|, sx/sy=+1/-1 by sign, err=dx+dy; arithmetic 12-bit signed, no overflow possible.
REQ-019 DRAW SHALL emit pixels along segment i by Bresenham: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy (both may apply in one step).
REQ-020 Each segment SHALL emit its start point and all intermediate points but not its end point, except segment NODES-2, which SHALL also emit its end point; total pixels per frame = sum of max(|dx|,|dy|) over segments + 1, before clipping.
REQ-021 A zero-length segment (identical nodes) SHALL emit nothing, except as last segment, where it SHALL emit the single point.
REQ-022 Pixels with x>=SCREEN_W or y>=SCREEN_H SHALL NOT be presented; the walker SHALL advance past them one point per cycle without asserting pix_valid.
REQ-023 Once pix_valid=1, pix_x/pix_y SHALL hold stable and pix_valid SHALL stay high until a cycle with pix_ready=1; transfer occurs on pix_valid&&pix_ready.
REQ-024 With pix_ready held 1, DRAW SHALL present one pixel per cycle; first pix_valid SHALL appear 2 cycles after the start-acceptance edge.
REQ-025 After a segment's last point transfers (or is clipped), SHALL go to LOAD for segment i+1 (one bubble cycle), or to FINISH after segment NODES-2.
REQ-026 FINISH SHALL last one cycle: done=1, then IDLE with busy=0 next cycle; start in FINISH SHALL be ignored.
REQ-027 pix_valid SHALL be 0 in IDLE, LOAD and FINISH.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0, segment index 0, independent of clk.
REQ-029 Reset mid-frame SHALL abandon the frame with no done pulse; first start after reset release SHALL begin a fresh snapshot.

Verification
REQ-030 NODES=2, nodes (0,0)->(5,0), pix_ready=1, start pulse -> pixels (0,0)..(5,0) on 6 consecutive cycles starting 2 cycles after start, done one cycle after last, busy low next.
REQ-031 NODES=2, (0,0)->(3,3) -> exactly (0,0),(1,1),(2,2),(3,3); then (3,0)->(0,2) -> (3,0),(2,1),(1,1),(0,2) with signed steps correct.
REQ-032 NODES=3, (10,10)->(12,10)->(12,12), pix_ready=1 -> (10,10),(11,10),(12,10),(12,11),(12,12), one-cycle bubble between segments, shared node emitted once.
REQ-033 NODES=20, all nodes (100,200) -> exactly one pixel (100,200), done after 19 LOAD cycles total.
REQ-034 NODES=2, (637,5)->(642,5) -> only (637,5),(638,5),(639,5) presented; done still pulses.
REQ-035 Random pix_ready back-pressure and a start pulse mid-frame -> coordinates stable while stalled, no pixel lost or duplicated, mid-frame start ignored; reset=0 mid-frame -> all outputs 0 immediately, no done.
